// File: rtl/vga_sync_gen.sv
// vga_sync_gen
//
// Generates VGA raster timing and paces a ready/valid pixel stream into the
// visible area. A frame is locked to the source by its start-of-packet beat:
// the beat carrying in_sop is only consumed on the first visible pixel (0,0).
// Losing lock (source underflow or a misplaced sop) drops back to re-alignment
// without disturbing the raster timing.
//
// Parameters
//   H_ACTIVE, H_FP, H_SYNC, H_BP : horizontal visible / porch / sync widths (clocks)
//   V_ACTIVE, V_FP, V_SYNC, V_BP : vertical visible / porch / sync widths (lines)
//
// Ports
//   clk          in   pixel clock, only clock
//   rst_n        in   synchronous active-low reset
//   enable       in   timing run request, honoured at frame end when dropped
//   in_data      in   24-bit RGB 8:8:8 pixel, R in [23:16]
//   in_valid     in   source beat valid
//   in_sop       in   beat is first pixel of a frame
//   in_ready     out  beat consumed (or discarded) this clock
//   vga_hs       out  horizontal sync, active low, registered
//   vga_vs       out  vertical sync, active low, registered
//   vga_blank_n  out  high in visible area, registered
//   vga_r/g/b    out  8-bit colour channels, registered, zero while blanked
//   underflow    out  sticky: source had no beat for a visible pixel
//   clr_err      in   clears underflow (a same-clock set wins)

module vga_sync_gen #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic [23:0] in_data,
    input  logic        in_valid,
    input  logic        in_sop,
    output logic        in_ready,
    output logic        vga_hs,
    output logic        vga_vs,
    output logic        vga_blank_n,
    output logic [7:0]  vga_r,
    output logic [7:0]  vga_g,
    output logic [7:0]  vga_b,
    output logic        underflow,
    input  logic        clr_err
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned H_W     = $clog2(H_TOTAL);
    localparam int unsigned V_W     = $clog2(V_TOTAL);

    localparam int unsigned H_SYNC_START = H_ACTIVE + H_FP;
    localparam int unsigned H_SYNC_END   = H_ACTIVE + H_FP + H_SYNC;
    localparam int unsigned V_SYNC_START = V_ACTIVE + V_FP;
    localparam int unsigned V_SYNC_END   = V_ACTIVE + V_FP + V_SYNC;

    typedef enum logic [1:0] {
        StDisabled,
        StAlign,
        StStream
    } state_e;

    state_e         state_q;
    logic [H_W-1:0] h_cnt_q;
    logic [V_W-1:0] v_cnt_q;

    // Counters widened once so every timing compare is done at 32 bits.
    logic [31:0] h_pos;
    logic [31:0] v_pos;

    logic h_active;
    logic v_active;
    logic active;
    logic at_origin;
    logic h_last;
    logic v_last;
    logic frame_end;
    logic h_sync_on;
    logic v_sync_on;
    logic sop_beat;
    logic beat_taken;
    logic pixel_shown;
    logic lose_lock;
    logic gain_lock;
    logic uf_set;

    assign h_pos = 32'(h_cnt_q);
    assign v_pos = 32'(v_cnt_q);

    // Raster decode from the current counter value.
    always_comb begin
        h_active  = (h_pos < H_ACTIVE);
        v_active  = (v_pos < V_ACTIVE);
        active    = h_active && v_active;
        at_origin = (h_pos == 32'd0) && (v_pos == 32'd0);
        h_last    = (h_pos == H_TOTAL - 1);
        v_last    = (v_pos == V_TOTAL - 1);
        frame_end = h_last && v_last;
        h_sync_on = (h_pos >= H_SYNC_START) && (h_pos < H_SYNC_END);
        v_sync_on = (v_pos >= V_SYNC_START) && (v_pos < V_SYNC_END);
    end

    // Handshake decode. A sop beat away from (0,0) is never accepted: while
    // aligning it is held for the next frame, while streaming it marks a
    // source that has slipped and forces re-alignment.
    always_comb begin
        sop_beat = in_valid && in_sop;
        in_ready = 1'b0;
        unique case (state_q)
            StDisabled: in_ready = 1'b0;
            StAlign:    in_ready = !sop_beat || at_origin;
            StStream:   in_ready = active && (!sop_beat || at_origin);
            default:    in_ready = 1'b0;
        endcase

        beat_taken = in_ready && in_valid;

        // While aligning, only the sop beat taken at the origin reaches the
        // screen; every other accepted beat is a discard.
        pixel_shown = 1'b0;
        if (beat_taken) begin
            if (state_q == StStream) begin
                pixel_shown = 1'b1;
            end else if (state_q == StAlign) begin
                pixel_shown = at_origin && in_sop;
            end
        end

        gain_lock = (state_q == StAlign) && at_origin && sop_beat;
        uf_set    = (state_q == StStream) && active && !in_valid;
        lose_lock = uf_set || ((state_q == StStream) && active && sop_beat && !at_origin);
    end

    // Single registered block: FSM, raster counters and every VGA output.
    // Outputs are computed from the counter value before the edge, so each
    // one lags its counter by exactly one clock and all stay mutually aligned.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= StDisabled;
            h_cnt_q     <= '0;
            v_cnt_q     <= '0;
            vga_hs      <= 1'b1;
            vga_vs      <= 1'b1;
            vga_blank_n <= 1'b0;
            vga_r       <= 8'd0;
            vga_g       <= 8'd0;
            vga_b       <= 8'd0;
            underflow   <= 1'b0;
        end else begin
            // Video outputs.
            if (state_q == StDisabled) begin
                vga_hs      <= 1'b1;
                vga_vs      <= 1'b1;
                vga_blank_n <= 1'b0;
                vga_r       <= 8'd0;
                vga_g       <= 8'd0;
                vga_b       <= 8'd0;
            end else begin
                vga_hs      <= !h_sync_on;
                vga_vs      <= !v_sync_on;
                vga_blank_n <= active;
                // pixel_shown implies active, so blanked pixels are always black.
                if (pixel_shown) begin
                    vga_r <= in_data[23:16];
                    vga_g <= in_data[15:8];
                    vga_b <= in_data[7:0];
                end else begin
                    vga_r <= 8'd0;
                    vga_g <= 8'd0;
                    vga_b <= 8'd0;
                end
            end

            // Sticky error; a set in the same clock as a clear wins.
            if (uf_set) begin
                underflow <= 1'b1;
            end else if (clr_err) begin
                underflow <= 1'b0;
            end

            // FSM and counters.
            unique case (state_q)
                StDisabled: begin
                    h_cnt_q <= '0;
                    v_cnt_q <= '0;
                    if (enable) begin
                        state_q <= StAlign;
                    end
                end
                StAlign, StStream: begin
                    if (frame_end) begin
                        h_cnt_q <= '0;
                        v_cnt_q <= '0;
                    end else if (h_last) begin
                        h_cnt_q <= '0;
                        v_cnt_q <= v_cnt_q + V_W'(1);
                    end else begin
                        h_cnt_q <= h_cnt_q + H_W'(1);
                    end

                    // A dropped enable is only acted on at frame end, so a
                    // re-assertion earlier in the frame simply cancels it.
                    if (frame_end && !enable) begin
                        state_q <= StDisabled;
                    end else if (gain_lock) begin
                        state_q <= StStream;
                    end else if (lose_lock) begin
                        state_q <= StAlign;
                    end
                end
                default: begin
                    state_q <= StDisabled;
                    h_cnt_q <= '0;
                    v_cnt_q <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vga_sync_gen.sv
module tb_vga_sync_gen;

    // Shrunk raster so whole frames run quickly.
    localparam int HA = 8;
    localparam int HF = 2;
    localparam int HS = 3;
    localparam int HB = 2;
    localparam int VA = 4;
    localparam int VF = 1;
    localparam int VS = 2;
    localparam int VB = 1;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int FRAME_CYC = HT * VT;
    localparam int FRAME_PIX = HA * VA;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic [23:0] in_data;
    logic        in_valid;
    logic        in_sop;
    logic        in_ready;
    logic        vga_hs;
    logic        vga_vs;
    logic        vga_blank_n;
    logic [7:0]  vga_r;
    logic [7:0]  vga_g;
    logic [7:0]  vga_b;
    logic        underflow;
    logic        clr_err;

    always #5 clk = ~clk;

    vga_sync_gen #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_sop      (in_sop),
        .in_ready    (in_ready),
        .vga_hs      (vga_hs),
        .vga_vs      (vga_vs),
        .vga_blank_n (vga_blank_n),
        .vga_r       (vga_r),
        .vga_g       (vga_g),
        .vga_b       (vga_b),
        .underflow   (underflow),
        .clr_err     (clr_err)
    );

    int checks = 0;
    int errors = 0;

    // Reference model state: 0 disabled, 1 aligning, 2 streaming.
    int m_state = 0;
    int mh = 0;
    int mv = 0;
    logic m_uf = 1'b0;
    int src_k = 0;

    // Expected {hs, vs, blank_n, rgb[23:0], underflow} after each edge.
    logic [27:0] exp_q[$];

    logic count_en = 1'b0;
    int hs_low = 0;
    int vs_low = 0;
    int blank_hi = 0;
    int rdy_cnt = 0;
    int sop_val = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One clock: compare last edge's outputs, drive this cycle, model it.
    task automatic run_cycle(input logic en, input logic rst_act, input logic drop,
                             input logic clr, input logic resync);
        logic [27:0] e;
        logic active;
        logic origin;
        logic sopb;
        logic rdy;
        logic fire;
        logic [23:0] rgb_e;
        int ns;
        @(posedge clk);
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check_eq("hs", 32'(vga_hs), 32'(e[27]));
            check_eq("vs", 32'(vga_vs), 32'(e[26]));
            check_eq("blank_n", 32'(vga_blank_n), 32'(e[25]));
            check_eq("rgb", 32'({vga_r, vga_g, vga_b}), 32'(e[24:1]));
            check_eq("underflow", 32'(underflow), 32'(e[0]));
        end
        if (count_en) begin
            hs_low   += (vga_hs == 1'b0) ? 1 : 0;
            vs_low   += (vga_vs == 1'b0) ? 1 : 0;
            blank_hi += (vga_blank_n == 1'b1) ? 1 : 0;
        end

        // Source: beat k carries data k, sop on every frame-sized boundary.
        if (resync) src_k = ((src_k / FRAME_PIX) + 1) * FRAME_PIX;
        rst_n    = !rst_act;
        enable   = en;
        in_valid = !drop;
        in_data  = 24'(src_k);
        in_sop   = ((src_k % FRAME_PIX) == 0);
        clr_err  = clr;
        #1;

        active = (mh < HA) && (mv < VA);
        origin = (mh == 0) && (mv == 0);
        sopb   = in_valid && in_sop;
        case (m_state)
            1:       rdy = !sopb || origin;
            2:       rdy = active && (!sopb || origin);
            default: rdy = 1'b0;
        endcase
        check_eq("in_ready", 32'(in_ready), 32'(rdy));
        if (count_en) rdy_cnt += rdy ? 1 : 0;
        fire = rdy && in_valid;
        if (fire) src_k++;

        if (rst_act) begin
            e = {1'b1, 1'b1, 1'b0, 24'd0, 1'b0};
            m_state = 0;
            mh = 0;
            mv = 0;
            m_uf = 1'b0;
        end else begin
            if (m_state == 2 && active && !in_valid) m_uf = 1'b1;
            else if (clr) m_uf = 1'b0;
            if (m_state == 0) begin
                e = {1'b1, 1'b1, 1'b0, 24'd0, m_uf};
                if (en) m_state = 1;
            end else begin
                rgb_e = 24'd0;
                if (fire && (m_state == 2 || (origin && in_sop))) rgb_e = in_data;
                e = {!(mh >= HA + HF && mh < HA + HF + HS),
                     !(mv >= VA + VF && mv < VA + VF + VS),
                     active, rgb_e, m_uf};
                ns = m_state;
                if (m_state == 1 && origin && sopb) ns = 2;
                if (m_state == 2 && active && (!in_valid || (sopb && !origin))) ns = 1;
                if (mh == HT - 1 && mv == VT - 1) begin
                    mh = 0;
                    mv = 0;
                    if (!en) ns = 0;
                end else if (mh == HT - 1) begin
                    mh = 0;
                    mv++;
                end else begin
                    mh++;
                end
                m_state = ns;
            end
        end
        exp_q.push_back(e);
    endtask

    // Run until the model raster sits at (x,y), bounded by a cycle budget.
    task automatic run_until(input int x, input int y, input logic en);
        int n = 0;
        while (!(mh == x && mv == y)) begin
            if (n >= 3 * FRAME_CYC) begin
                check_eq("run_until_reached", 32'(mh * 1000 + mv), 32'(x * 1000 + y));
                return;
            end
            run_cycle(en, 1'b0, 1'b0, 1'b0, 1'b0);
            n++;
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        enable   = 1'b0;
        in_valid = 1'b0;
        in_sop   = 1'b0;
        in_data  = 24'd0;
        clr_err  = 1'b0;

        // Reset, then idle in DISABLED.
        run_cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        run_cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        check_eq("reset_hs", 32'(vga_hs), 32'd1);
        check_eq("reset_blank_n", 32'(vga_blank_n), 32'd0);
        run_cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Steady streaming for three frames; count one full frame of outputs.
        for (int i = 0; i < 3 * FRAME_CYC + 1; i++) begin
            count_en = (i >= FRAME_CYC + 1) && (i < 2 * FRAME_CYC + 1);
            run_cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        end
        count_en = 1'b0;
        check_eq("hs_low_per_frame", 32'(hs_low), 32'(VT * HS));
        check_eq("vs_low_per_frame", 32'(vs_low), 32'(HT * VS));
        check_eq("blank_hi_per_frame", 32'(blank_hi), 32'(HA * VA));
        check_eq("ready_per_frame", 32'(rdy_cnt), 32'(HA * VA));

        // Underflow at (3,2): black pixel, sticky flag, resync at next frame.
        run_until(3, 2, 1'b1);
        run_cycle(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        run_cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check_eq("uf_set", 32'(underflow), 32'd1);
        check_eq("uf_black", 32'({vga_r, vga_g, vga_b}), 32'd0);
        check_eq("uf_blank_n", 32'(vga_blank_n), 32'd1);
        run_until(0, 0, 1'b1);
        repeat (5) run_cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        run_cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        run_cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check_eq("uf_cleared", 32'(underflow), 32'd0);

        // Misplaced sop at (5,0): held until the next origin, taken there.
        run_until(0, 1, 1'b1);
        run_until(5, 0, 1'b1);
        run_cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        sop_val = src_k;
        check_eq("sop_held_ready", 32'(in_ready), 32'd0);
        run_until(0, 0, 1'b1);
        run_cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check_eq("sop_taken_ready", 32'(in_ready), 32'd1);
        run_cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check_eq("sop_taken_rgb", 32'({vga_r, vga_g, vga_b}), 32'(sop_val));
        check_eq("no_uf_on_sop", 32'(underflow), 32'd0);

        // Enable dropped then restored mid-frame: no effect.
        run_until(4, 1, 1'b1);
        run_until(2, 3, 1'b0);
        run_until(0, 0, 1'b1);
        run_cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        run_cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check_eq("cancel_blank_n", 32'(vga_blank_n), 32'd1);

        // Enable dropped at (4,2): frame completes, then DISABLED.
        run_until(4, 2, 1'b1);
        run_until(0, 0, 1'b0);
        repeat (3) run_cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check_eq("dis_hs", 32'(vga_hs), 32'd1);
        check_eq("dis_vs", 32'(vga_vs), 32'd1);
        check_eq("dis_blank_n", 32'(vga_blank_n), 32'd0);
        check_eq("dis_ready", 32'(in_ready), 32'd0);

        // Re-enable, stream a frame, then reset mid-line.
        for (int i = 0; i < FRAME_CYC + 3; i++) run_cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        run_until(3, 1, 1'b1);
        run_cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        run_cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check_eq("rst_hs", 32'(vga_hs), 32'd1);
        check_eq("rst_vs", 32'(vga_vs), 32'd1);
        check_eq("rst_blank_n", 32'(vga_blank_n), 32'd0);
        check_eq("rst_rgb", 32'({vga_r, vga_g, vga_b}), 32'd0);
        check_eq("rst_uf", 32'(underflow), 32'd0);
        for (int i = 0; i < FRAME_CYC + 5; i++) run_cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/vga_sync_gen.md
VGA_SYNC_GEN -- requirements
Module: vga_sync_gen

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 640, visible pixels per line.
REQ-002 SHALL have parameters H_FP, H_SYNC, H_BP, defaults 16, 96, 48, horizontal porch and sync widths in clocks.
REQ-003 SHALL have parameter V_ACTIVE, default 480, visible lines per frame.
REQ-004 SHALL have parameters V_FP, V_SYNC, V_BP, defaults 10, 2, 33, vertical porch and sync widths in lines.
REQ-005 SHALL have port clk, input, 1, pixel clock (25.175 MHz outclk_0 of VGA PLL); only clock.
REQ-006 SHALL have port rst_n, input, 1, synchronous active-low reset.
REQ-007 SHALL have port enable, input, 1, timing run request.
REQ-008 SHALL have ports in_data (input, 24, RGB 8:8:8, R in [23:16]), in_valid (input, 1), in_sop (input, 1, first pixel of frame), in_ready (output, 1).
REQ-009 SHALL have ports vga_hs and vga_vs, output, 1 each, active-low syncs.
REQ-010 SHALL have ports vga_blank_n (output, 1, high in visible area) and vga_r, vga_g, vga_b (output, 8 each).
REQ-011 SHALL have port underflow, output, 1, sticky error flag.
REQ-012 SHALL have port clr_err, input, 1, clears underflow.

Function
REQ-013 SHALL keep h_cnt 0..H_TOTAL-1 (H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP = 800), wrapping to 0 and advancing v_cnt 0..V_TOTAL-1 (525), which wraps to 0.
REQ-014 SHALL define active = (h_cnt < H_ACTIVE) && (v_cnt < V_ACTIVE); hsync asserted for H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC; vsync likewise on v_cnt.
REQ-015 SHALL register all VGA outputs, each lagging its counter value by exactly 1 clock; hs, vs, blank_n and RGB mutually aligned.
REQ-016 SHALL output RGB = 0 whenever blank_n is low.
REQ-017 SHALL implement states DISABLED, ALIGN, STREAM.
REQ-018 DISABLED: counters held at 0, in_ready=0, hs=vs=1, blank_n=0; enable=1 -> ALIGN next clock, counters start from (0,0).
REQ-019 ALIGN: non-sop beats discarded (in_ready=1, in_valid=1, in_sop=0); sop beat held (in_ready=0) except at active (0,0), where consumed -> STREAM; pixels output black, blank_n follows timing.
REQ-020 STREAM: in_ready = active; beat consumed when in_ready && in_valid; consumed in_data drives RGB next clock.
REQ-021 STREAM, active and in_valid=0: black pixel, underflow set, -> ALIGN; counters unaffected.
REQ-022 STREAM, in_sop=1 at active pixel other than (0,0): beat not consumed (in_ready=0 that clock), pixel black, -> ALIGN; underflow not set.
REQ-023 enable=0 SHALL take effect only at h_cnt=H_TOTAL-1, v_cnt=V_TOTAL-1 (frame end), then -> DISABLED; enable re-asserted before frame end cancels.
REQ-024 underflow SHALL clear on clr_err=1; simultaneous set and clr_err -> set wins.
REQ-025 Counter widths SHALL be ceil(log2(TOTAL)); no overflow beyond TOTAL-1.

Reset
REQ-026 rst_n=0 at clk edge SHALL force DISABLED, counters 0, in_ready=0, vga_hs=1, vga_vs=1, vga_blank_n=0, RGB=0, underflow=0, overriding all inputs including mid-frame.

Verification
REQ-027 Reset, enable=1, source always valid, sop at each frame start -> hs low 96 clocks per 800-clock line, vs low 2 lines per 525, blank_n high 640x480 per frame, in_ready count = 307200 per frame.
REQ-028 Feed pixel n = 24'h000000+n from sop -> vga_r/g/b for (x,y) equal beat y*640+x, one clock after in_ready handshake, no skipped/repeated beats.
REQ-029 Drop in_valid at pixel (100,10) one clock -> pixel black, underflow=1, non-sop beats discarded, streaming resumes at next frame (0,0) sop; clr_err -> underflow=0.
REQ-030 Present sop at (5,0) mid-stream -> in_ready=0 that clock, ALIGN, sop held until next (0,0), consumed then.
REQ-031 Deassert enable at (320,240) -> timing continues to frame end, then DISABLED outputs (hs=vs=1, blank_n=0); rst_n=0 mid-line -> all REQ-026 values next clock.
